// File: rtl/clk_div_multi_if.sv
// Divisor configuration port for clk_div_multi.
//   cfg_valid : write request from the master
//   cfg_ready : write can be accepted (driven combinationally by the divider)
//   cfg_ch    : target channel of the write
//   cfg_div   : new half-period divisor, 0 halts the channel
// Modports: master (drives the request), slave (the divider).
interface clk_div_multi_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    output cfg_ready
  );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider.
// Each of NUM_CH channels produces a square wave with a half-period of active_div cycles and a
// one-cycle tick on every clk_out edge. Divisor writes land in a shadow register and are
// applied only at a half-period boundary (or at once while the channel is stopped), so the
// output never glitches.
// Ports:
//   clk_in     : system clock, rising edge
//   rst        : synchronous active-high reset
//   sync_pulse : phase-align all enabled channels (only with CLKDIV_SYNC_EN defined)
//   ch_en      : per-channel run enable
//   cfg        : divisor write port (clk_div_multi_if.slave)
//   clk_out    : divided square waves, registered
//   tick       : one-cycle pulse coincident with each clk_out edge, registered
//   pending    : per-channel divisor write waiting for its boundary
// Optional feature macro: CLKDIV_SYNC_EN adds the sync_pulse input.
module clk_div_multi #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 50_000_000
) (
  input  logic              clk_in,
  input  logic              rst,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync_pulse,
`endif
  input  logic [NUM_CH-1:0] ch_en,
  clk_div_multi_if.slave    cfg,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [CNT_W-1:0]  active_q [NUM_CH];
  logic [CNT_W-1:0]  active_d [NUM_CH];
  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [CNT_W-1:0]  shadow_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;

  // Out-of-range channel numbers are always ready and their writes are dropped.
  logic ch_in_range;
  assign ch_in_range   = ({1'b0, cfg.cfg_ch} < (CH_W + 1)'(NUM_CH));
  assign cfg.cfg_ready = ch_in_range ? ~pend_q[cfg.cfg_ch] : 1'b1;

  always_comb begin
    logic apply;
    logic run;
    logic accept;

    cnt_d    = cnt_q;
    active_d = active_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    clk_d    = clk_q;
    tick_d   = '0;

    for (int unsigned i = 0; i < NUM_CH; i++) begin
      apply  = 1'b0;
      run    = ch_en[i] && (active_q[i] != '0);
      accept = cfg.cfg_valid && cfg.cfg_ready && ch_in_range && (cfg.cfg_ch == CH_W'(i));

`ifdef CLKDIV_SYNC_EN
      if (sync_pulse && ch_en[i]) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
        apply    = pend_q[i];
      end else
`endif
      if (run) begin
        if (cnt_q[i] == active_q[i] - CNT_W'(1)) begin
          // Half-period boundary: the only point where a running channel may change divisor.
          cnt_d[i]  = '0;
          clk_d[i]  = ~clk_q[i];
          tick_d[i] = 1'b1;
          apply     = pend_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
        apply    = pend_q[i];
      end

      if (apply) begin
        active_d[i] = shadow_q[i];
        pend_d[i]   = 1'b0;
      end
      // accept implies pend_q[i] == 0, so it never collides with apply.
      if (accept) begin
        shadow_d[i] = cfg.cfg_div;
        pend_d[i]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q    <= '{default: '0};
      active_q <= '{default: DefDiv};
      shadow_q <= '{default: DefDiv};
      pend_q   <= '0;
      clk_q    <= '0;
      tick_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Randomized bench for clk_div_multi against a timestamp-based reference model.
module tb_clk_div_multi;

  localparam int unsigned NCH = 3;
  localparam int unsigned CW  = 8;
  localparam int unsigned DEF = 3;

  logic           clk_in = 1'b0;
  logic           rst;
  logic [NCH-1:0] ch_en;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] pending;
  bit             sync_v;

  clk_div_multi_if #(.NUM_CH(NCH), .CNT_W(CW)) cfg_if ();

  clk_div_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DEF)) dut (
    .clk_in  (clk_in),
    .rst     (rst),
`ifdef CLKDIV_SYNC_EN
    .sync_pulse (sync_v),
`endif
    .ch_en   (ch_en),
    .cfg     (cfg_if),
    .clk_out (clk_out),
    .tick    (tick),
    .pending (pending)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;
  int cyc;

  // Model: each half-period is described by the cycle it started counting in and its length.
  int m_start [NCH];
  int m_act   [NCH];
  int m_shad  [NCH];
  bit m_pend  [NCH];
  bit m_clk   [NCH];
  bit m_tick  [NCH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit model_ready(input int ch);
    return (ch >= NCH) ? 1'b1 : !m_pend[ch];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_start[i] = cyc + 1;
      m_act[i]   = DEF;
      m_shad[i]  = DEF;
      m_pend[i]  = 0;
      m_clk[i]   = 0;
      m_tick[i]  = 0;
    end
  endtask

  // Advance the model across edge number cyc with the given inputs.
  task automatic model_step(input logic [NCH-1:0] en, input bit valid, input int ch,
                            input int div, input bit r);
    bit acc;
    bit apply;
    if (r) begin
      model_reset();
      return;
    end
    acc = valid && (ch < NCH) && model_ready(ch);
    for (int i = 0; i < NCH; i++) begin
      apply     = 0;
      m_tick[i] = 0;
      if (sync_v && en[i]) begin
        m_clk[i]   = 0;
        m_start[i] = cyc + 1;
        apply      = m_pend[i];
      end else if (en[i] && m_act[i] != 0) begin
        if (cyc - m_start[i] == m_act[i] - 1) begin
          m_clk[i]   = !m_clk[i];
          m_tick[i]  = 1;
          m_start[i] = cyc + 1;
          apply      = m_pend[i];
        end
      end else begin
        m_clk[i]   = 0;
        m_start[i] = cyc + 1;
        apply      = m_pend[i];
      end
      if (apply) begin
        m_act[i]  = m_shad[i];
        m_pend[i] = 0;
      end
    end
    if (acc) begin
      m_shad[ch] = div;
      m_pend[ch] = 1;
    end
  endtask

  // One clock: drive inputs, check combinational ready, step model, check registered outputs.
  task automatic cycle(input logic [NCH-1:0] en, input bit valid, input int ch, input int div,
                       input bit r);
    logic [NCH-1:0] e_clk, e_tick, e_pend;
    rst              = r;
    ch_en            = en;
    cfg_if.cfg_valid = valid;
    cfg_if.cfg_ch    = 2'(ch);
    cfg_if.cfg_div   = CW'(div);
    #1;
    check("cfg_ready", 32'(cfg_if.cfg_ready), 32'(model_ready(ch)));
    model_step(en, valid, ch, div, r);
    @(posedge clk_in);
    #1;
    for (int i = 0; i < NCH; i++) begin
      e_clk[i]  = m_clk[i];
      e_tick[i] = m_tick[i];
      e_pend[i] = m_pend[i];
    end
    check("clk_out", 32'(clk_out), 32'(e_clk));
    check("tick", 32'(tick), 32'(e_tick));
    check("pending", 32'(pending), 32'(e_pend));
    cyc++;
  endtask

  logic [NCH-1:0] en_r;
  int             dv;

  initial begin
    bit exp_clk [6];
    bit exp_tick[6];
    exp_clk  = '{0, 0, 1, 1, 1, 0};
    exp_tick = '{0, 0, 1, 0, 0, 1};
    sync_v           = 0;
    rst              = 1'b1;
    ch_en            = '0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_div   = '0;
    repeat (2) @(posedge clk_in);
    #1;
    cyc = 0;
    model_reset();
    cyc = 1;
    check("rst_clk_out", 32'(clk_out), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_cfg_ready", 32'(cfg_if.cfg_ready), 32'h1);

    // Default divisor of 3 on channel 0: edges after the 3rd and 6th clock.
    for (int k = 0; k < 6; k++) begin
      cycle(3'b001, 0, 0, 0, 1'b0);
      check("dflt_clk0", 32'(clk_out[0]), 32'(exp_clk[k]));
      check("dflt_tick0", 32'(tick[0]), 32'(exp_tick[k]));
    end

    // Directed: ch1 at D=4 then D=2 mid-period; stalled second write; D=1; D=0; bad channel.
    cycle(3'b011, 1, 1, 4, 1'b0);
    repeat (5) cycle(3'b011, 0, 0, 0, 1'b0);
    cycle(3'b011, 1, 1, 2, 1'b0);
    check("pend_ready_ch1", 32'(cfg_if.cfg_ready), 32'h0);
    repeat (3) cycle(3'b011, 1, 1, 1, 1'b0);
    repeat (8) cycle(3'b111, 0, 0, 0, 1'b0);
    cycle(3'b111, 1, 2, 5, 1'b0);
    cycle(3'b011, 0, 0, 0, 1'b0);
    check("drop_en_clk2", 32'(clk_out[2]), 32'h0);
    check("drop_en_pend2", 32'(pending[2]), 32'h0);
    repeat (12) cycle(3'b111, 0, 0, 0, 1'b0);
    cycle(3'b111, 1, 0, 0, 1'b0);
    repeat (8) cycle(3'b111, 0, 0, 0, 1'b0);
    check("halt_clk0", 32'(clk_out[0]), 32'h0);
    cycle(3'b111, 1, 3, 7, 1'b0);
    check("bad_ch_pend", 32'(pending), 32'h0);

    // Random phase.
    en_r = 3'b111;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) en_r[$urandom_range(0, NCH - 1)] ^= 1'b1;
      dv = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
`ifdef CLKDIV_SYNC_EN
      sync_v = ($urandom_range(0, 49) == 0);
`endif
      cycle(en_r, ($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)), dv,
            ($urandom_range(0, 299) == 0));
    end
    sync_v = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
